// File: rtl/seq_alu.sv
// seq_alu: registered WIDTH-bit ALU with iterative multiply/divide behind a START/BUSY/DONE handshake.
// Latency: single-cycle ops DONE one edge after accept; MUL/DIVU (nonzero divisor) DONE WIDTH+1 edges after accept.
// Backpressure: START is ignored while BUSY=1; operands are latched on accept, so later input changes have no effect.
// Ports:
//   CLK, RESET (sync, active-high), START, SELECT[3:0], DATA1/DATA2[WIDTH-1:0]  -- inputs
//   RESULT/RESULT_HI[WIDTH-1:0], ZERO, CARRY, DIV0, ILLEGAL, BUSY, DONE        -- registered outputs
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [3:0]       SELECT,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  output logic [WIDTH-1:0] RESULT,
  output logic [WIDTH-1:0] RESULT_HI,
  output logic             ZERO,
  output logic             CARRY,
  output logic             DIV0,
  output logic             ILLEGAL,
  output logic             BUSY,
  output logic             DONE
);

  localparam int SHAMT_W = $clog2(WIDTH);

  localparam logic [3:0] OP_FWD  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_MUL  = 4'h4;
  localparam logic [3:0] OP_LSH  = 4'h5;
  localparam logic [3:0] OP_ASR  = 4'h6;
  localparam logic [3:0] OP_ROR  = 4'h7;
  localparam logic [3:0] OP_SUB  = 4'h8;
  localparam logic [3:0] OP_XOR  = 4'h9;
  localparam logic [3:0] OP_DIVU = 4'hA;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;

  state_t             state;
  logic [3:0]         op_sel;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [SHAMT_W-1:0] cnt;
  // Shared iteration registers: MUL keeps {partial high, multiplier/low}, DIV keeps {remainder, quotient}.
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;

  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     sub_diff;
  logic [WIDTH-1:0]   asr_res;
  logic [WIDTH-1:0]   rot_res;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_trial;
  logic               div_ge;

  logic [WIDTH-1:0]   fin_lo;
  logic [WIDTH-1:0]   fin_hi;
  logic               fin_carry;
  logic               fin_div0;
  logic               fin_ill;

  assign shamt    = op_b[SHAMT_W-1:0];
  assign add_sum  = {1'b0, op_a} + {1'b0, op_b};
  assign sub_diff = {1'b0, op_a} - {1'b0, op_b};
  assign asr_res  = $signed(op_a) >>> shamt;

  // One shift-add step: add the multiplicand when the current multiplier LSB is set,
  // then shift the whole {acc_hi, acc_lo} pair right, carry entering at the top.
  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, op_a} : '0);

  // One restoring-division step: bring the next dividend bit into the remainder and
  // subtract the divisor; no borrow means the trial fits and the quotient bit is 1.
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, op_b};
  assign div_ge    = ~div_trial[WIDTH];

  always_comb begin
    rot_res = '0;
    for (int i = 0; i < WIDTH; i++) begin
      rot_res[i] = op_a[(i + int'(shamt)) % WIDTH];
    end
  end

  // Final result selection from the latched operands (or accumulators for MUL/DIV).
  always_comb begin
    fin_lo    = '0;
    fin_hi    = '0;
    fin_carry = 1'b0;
    fin_div0  = 1'b0;
    fin_ill   = 1'b0;
    case (op_sel)
      OP_FWD: fin_lo = op_b;
      OP_ADD: begin
        fin_lo    = add_sum[WIDTH-1:0];
        fin_carry = add_sum[WIDTH];
      end
      OP_AND: fin_lo = op_a & op_b;
      OP_OR:  fin_lo = op_a | op_b;
      OP_MUL: begin
        fin_lo = acc_lo;
        fin_hi = acc_hi;
      end
      OP_LSH: fin_lo = op_b[WIDTH-1] ? (op_a << shamt) : (op_a >> shamt);
      OP_ASR: fin_lo = asr_res;
      OP_ROR: fin_lo = rot_res;
      OP_SUB: begin
        fin_lo    = sub_diff[WIDTH-1:0];
        fin_carry = ~sub_diff[WIDTH];
      end
      OP_XOR: fin_lo = op_a ^ op_b;
      OP_DIVU: begin
        if (op_b == '0) begin
          fin_lo   = '1;
          fin_hi   = op_a;
          fin_div0 = 1'b1;
        end else begin
          fin_lo = acc_lo;
          fin_hi = acc_hi;
        end
      end
      default: fin_ill = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= S_IDLE;
      op_sel    <= '0;
      op_a      <= '0;
      op_b      <= '0;
      cnt       <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      RESULT    <= '0;
      RESULT_HI <= '0;
      ZERO      <= 1'b0;
      CARRY     <= 1'b0;
      DIV0      <= 1'b0;
      ILLEGAL   <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      DONE <= 1'b0;

      case (state)
        S_IDLE: begin
          if (START) begin
            ZERO    <= 1'b0;
            CARRY   <= 1'b0;
            DIV0    <= 1'b0;
            ILLEGAL <= 1'b0;
          end
        end
        S_MUL: begin
          acc_hi <= mul_sum[WIDTH:1];
          acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          if (cnt == '0) begin
            state <= S_FIN;
            BUSY  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DIV: begin
          acc_hi <= div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
          acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
          if (cnt == '0) begin
            state <= S_FIN;
            BUSY  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_FIN: begin
          RESULT    <= fin_lo;
          RESULT_HI <= fin_hi;
          ZERO      <= (fin_lo == '0);
          CARRY     <= fin_carry;
          DIV0      <= fin_div0;
          ILLEGAL   <= fin_ill;
          DONE      <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // Accept in IDLE or FIN; in FIN this overrides the return to IDLE (back-to-back issue).
      if (START && (state == S_IDLE || state == S_FIN)) begin
        op_sel <= SELECT;
        op_a   <= DATA1;
        op_b   <= DATA2;
        cnt    <= {SHAMT_W{1'b1}};
        if (SELECT == OP_MUL) begin
          state  <= S_MUL;
          BUSY   <= 1'b1;
          acc_hi <= '0;
          acc_lo <= DATA2;
        end else if (SELECT == OP_DIVU && DATA2 != '0) begin
          state  <= S_DIV;
          BUSY   <= 1'b1;
          acc_hi <= '0;
          acc_lo <= DATA1;
        end else begin
          state <= S_FIN;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;

  localparam int W    = 8;
  localparam int MOD  = 1 << W;
  localparam int MASK = MOD - 1;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         START;
  logic [3:0]   SELECT;
  logic [W-1:0] DATA1, DATA2;
  logic [W-1:0] RESULT, RESULT_HI;
  logic         ZERO, CARRY, DIV0, ILLEGAL, BUSY, DONE;

  int n_cmp = 0;
  int n_bad = 0;

  seq_alu #(.WIDTH(W)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .SELECT(SELECT),
    .DATA1(DATA1), .DATA2(DATA2), .RESULT(RESULT), .RESULT_HI(RESULT_HI),
    .ZERO(ZERO), .CARRY(CARRY), .DIV0(DIV0), .ILLEGAL(ILLEGAL),
    .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  // Reference model: plain arithmetic on ints, straight from the opcode definitions.
  function automatic void model(input int sel, input int a, input int b,
                                output int lo, output int hi,
                                output bit z, output bit c, output bit d0, output bit il);
    int s, sa;
    lo = 0; hi = 0; c = 0; d0 = 0; il = 0;
    s = b % W;
    case (sel)
      0:  lo = b;
      1:  begin lo = (a + b) % MOD; c = (a + b) >= MOD; end
      2:  lo = a & b;
      3:  lo = a | b;
      4:  begin lo = (a * b) % MOD; hi = (a * b) / MOD; end
      5:  lo = (b >= MOD / 2) ? (a * (1 << s)) % MOD : a / (1 << s);
      6:  begin sa = (a >= MOD / 2) ? a - MOD : a; lo = (sa >>> s) & MASK; end
      7:  lo = ((a >> s) | (a << (W - s))) & MASK;
      8:  begin lo = (a - b + MOD) % MOD; c = a >= b; end
      9:  lo = a ^ b;
      10: if (b == 0) begin lo = MASK; hi = a; d0 = 1; end
          else begin lo = a / b; hi = a % b; end
      default: il = 1;
    endcase
    z = (lo == 0);
  endfunction

  function automatic int model_lat(input int sel, input int b);
    return (sel == 4 || (sel == 10 && b != 0)) ? W + 1 : 1;
  endfunction

  // Issue one op from an idle/done DUT; lat counts edges after the accepting edge.
  // Operands are scrambled after accept to show they no longer matter.
  task automatic run_op(input int sel, input int a, input int b,
                        output int lat, output int busy_cyc, output bit to);
    SELECT = sel[3:0]; DATA1 = a[W-1:0]; DATA2 = b[W-1:0]; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    DATA1 = $urandom; DATA2 = $urandom; SELECT = $urandom;
    lat = 0; busy_cyc = 0;
    while (!DONE && lat < 40) begin
      if (BUSY) busy_cyc++;
      @(posedge CLK); #1;
      lat++;
    end
    to = !DONE;
  endtask

  task automatic test_reset;
    RESET = 1'b1; START = 1'b0; SELECT = '0; DATA1 = '0; DATA2 = '0;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    n_cmp++;
    if ({RESULT, RESULT_HI, ZERO, CARRY, DIV0, ILLEGAL, BUSY, DONE} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got %h/%h flags %b%b%b%b busy %b done %b, want all 0",
               RESULT, RESULT_HI, ZERO, CARRY, DIV0, ILLEGAL, BUSY, DONE);
    end
  endtask

  typedef struct {
    int sel; int a; int b;
    int lo; int hi; bit z; bit c; bit d0; bit il; int lat;
  } vec_t;

  task automatic test_directed;
    vec_t v[$];
    int lat, bc; bit to;
    v.push_back('{1,  'hFF, 'h01, 'h00, 'h00, 1, 1, 0, 0, 1});
    v.push_back('{8,  'h05, 'h07, 'hFE, 'h00, 0, 0, 0, 0, 1});
    v.push_back('{8,  'h07, 'h07, 'h00, 'h00, 1, 1, 0, 0, 1});
    v.push_back('{4,  'hFF, 'hFF, 'h01, 'hFE, 0, 0, 0, 0, 9});
    v.push_back('{10, 200,  7,    28,   4,    0, 0, 0, 0, 9});
    v.push_back('{10, 'h2A, 'h00, 'hFF, 'h2A, 0, 0, 1, 0, 1});
    v.push_back('{5,  'h81, 'h83, 'h08, 'h00, 0, 0, 0, 0, 1});
    v.push_back('{5,  'h81, 'h01, 'h40, 'h00, 0, 0, 0, 0, 1});
    v.push_back('{6,  'h80, 'h02, 'hE0, 'h00, 0, 0, 0, 0, 1});
    v.push_back('{7,  'h01, 'h01, 'h80, 'h00, 0, 0, 0, 0, 1});
    v.push_back('{0,  'h12, 'h9A, 'h9A, 'h00, 0, 0, 0, 0, 1});
    v.push_back('{12, 'h12, 'h34, 'h00, 'h00, 1, 0, 0, 1, 1});
    foreach (v[i]) begin
      run_op(v[i].sel, v[i].a, v[i].b, lat, bc, to);
      n_cmp++;
      if (to) begin
        n_bad++;
        $display("FAIL dir%0d_timeout: no DONE within 40 cycles", i);
      end
      n_cmp++;
      if ({RESULT, RESULT_HI, ZERO, CARRY, DIV0, ILLEGAL} !==
          {v[i].lo[W-1:0], v[i].hi[W-1:0], v[i].z, v[i].c, v[i].d0, v[i].il}) begin
        n_bad++;
        $display("FAIL dir%0d_value: got %h/%h z%b c%b d%b i%b, want %h/%h z%b c%b d%b i%b", i,
                 RESULT, RESULT_HI, ZERO, CARRY, DIV0, ILLEGAL,
                 v[i].lo[W-1:0], v[i].hi[W-1:0], v[i].z, v[i].c, v[i].d0, v[i].il);
      end
      n_cmp++;
      if (lat !== v[i].lat || bc !== v[i].lat - 1) begin
        n_bad++;
        $display("FAIL dir%0d_timing: got lat %0d busy %0d, want lat %0d busy %0d",
                 i, lat, bc, v[i].lat, v[i].lat - 1);
      end
    end
    // DONE is a single-cycle pulse and the result is held afterwards.
    @(posedge CLK); #1;
    n_cmp++;
    if (DONE !== 1'b0 || ILLEGAL !== 1'b1 || RESULT !== 8'h00) begin
      n_bad++;
      $display("FAIL done_pulse: got done %b ill %b res %h, want done 0 ill 1 res 00",
               DONE, ILLEGAL, RESULT);
    end
  endtask

  task automatic test_random;
    int a, b, sel, lo, hi, lat, bc, elat;
    bit z, c, d0, il, to;
    for (int k = 0; k < 150; k++) begin
      sel = $urandom_range(0, 15);
      a = $urandom_range(0, MASK);
      b = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, MASK);
      model(sel, a, b, lo, hi, z, c, d0, il);
      elat = model_lat(sel, b);
      run_op(sel, a, b, lat, bc, to);
      n_cmp++;
      if (to || lat !== elat ||
          {RESULT, RESULT_HI, ZERO, CARRY, DIV0, ILLEGAL} !==
          {lo[W-1:0], hi[W-1:0], z, c, d0, il}) begin
        n_bad++;
        $display("FAIL rand%0d op%0d %h,%h: got %h/%h z%b c%b d%b i%b lat %0d, want %h/%h z%b c%b d%b i%b lat %0d",
                 k, sel, a, b, RESULT, RESULT_HI, ZERO, CARRY, DIV0, ILLEGAL, lat,
                 lo[W-1:0], hi[W-1:0], z, c, d0, il, elat);
      end
    end
  endtask

  task automatic test_reset_mid;
    int lat, bc; bit to, seen;
    run_op(1, 'h21, 'h13, lat, bc, to);   // leave nonzero outputs behind
    SELECT = 4'h4; DATA1 = 8'hFF; DATA2 = 8'hFF; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (3) begin @(posedge CLK); #1; end
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    n_cmp++;
    if ({RESULT, RESULT_HI, ZERO, CARRY, DIV0, ILLEGAL, BUSY, DONE} !== '0) begin
      n_bad++;
      $display("FAIL midreset_state: got %h/%h flags %b%b%b%b busy %b done %b, want all 0",
               RESULT, RESULT_HI, ZERO, CARRY, DIV0, ILLEGAL, BUSY, DONE);
    end
    seen = 0;
    repeat (12) begin
      @(posedge CLK); #1;
      if (DONE || BUSY) seen = 1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_abort: got done/busy activity %b, want 0", seen);
    end
    run_op(1, 3, 4, lat, bc, to);
    n_cmp++;
    if (to || lat !== 1 || RESULT !== 8'd7) begin
      n_bad++;
      $display("FAIL midreset_recover: got res %h lat %0d, want 07 lat 1", RESULT, lat);
    end
  endtask

  task automatic test_busy_ignore;
    int lat; bit busy_ok;
    SELECT = 4'h4; DATA1 = 8'hFF; DATA2 = 8'hFF; START = 1'b1;
    @(posedge CLK); #1;
    SELECT = 4'h1; DATA1 = 8'h01; DATA2 = 8'h01;   // START stays high: must be ignored
    lat = 0; busy_ok = 1;
    repeat (3) begin
      if (!BUSY) busy_ok = 0;
      @(posedge CLK); #1;
      lat++;
    end
    START = 1'b0;
    while (!DONE && lat < 40) begin
      @(posedge CLK); #1;
      lat++;
    end
    n_cmp++;
    if (!busy_ok || lat !== 9 || RESULT !== 8'h01 || RESULT_HI !== 8'hFE) begin
      n_bad++;
      $display("FAIL busy_ignore: got busy_ok %b lat %0d res %h/%h, want 1 9 01/FE",
               busy_ok, lat, RESULT, RESULT_HI);
    end
    repeat (3) begin @(posedge CLK); #1; end
    n_cmp++;
    if (DONE !== 1'b0 || RESULT !== 8'h01) begin
      n_bad++;
      $display("FAIL busy_ignore_late: got done %b res %h, want 0 01", DONE, RESULT);
    end
  endtask

  task automatic test_back_to_back;
    SELECT = 4'h1; DATA1 = 8'd10; DATA2 = 8'd20; START = 1'b1;
    @(posedge CLK); #1;
    n_cmp++;
    if (BUSY !== 1'b0 || DONE !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_fin: got busy %b done %b, want 0 0", BUSY, DONE);
    end
    SELECT = 4'h8; DATA1 = 8'd50; DATA2 = 8'd8;   // issued in the FIN cycle
    @(posedge CLK); #1;
    START = 1'b0;
    n_cmp++;
    if (DONE !== 1'b1 || RESULT !== 8'd30) begin
      n_bad++;
      $display("FAIL b2b_first: got done %b res %0d, want 1 30", DONE, RESULT);
    end
    @(posedge CLK); #1;
    n_cmp++;
    if (DONE !== 1'b1 || RESULT !== 8'd42 || CARRY !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_second: got done %b res %0d c %b, want 1 42 1", DONE, RESULT, CARRY);
    end
    @(posedge CLK); #1;
    n_cmp++;
    if (DONE !== 1'b0 || RESULT !== 8'd42) begin
      n_bad++;
      $display("FAIL b2b_hold: got done %b res %0d, want 0 42", DONE, RESULT);
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_reset_mid;
    test_busy_ignore;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
